// File: rtl/ddr4_cmd_driver.sv
// ---------------------------------------------------------------------------
// ddr4_cmd_driver
//
// Controller-side initiator for a DDR4 command/address pin bundle. Abstract
// commands arrive over a valid/ready handshake and leave as JEDEC-encoded CA
// pins, one CA slot per clock. The block also sequences DRAM power-up
// (RESET_n then CKE) and holds off the next command until the minimum gap
// for the previous one has elapsed.
//
// Optional feature: define DDR4_CA_PARITY_EN to generate even CA parity on
// PARITY. Without it PARITY is tied low and no parity logic exists.
//
// Ports
//   clk, rst                 controller clock; asynchronous active-high reset
//   cmd_valid / cmd_ready    handshake; command taken when both are high
//   cmd_type                 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS
//   cmd_rank                 target rank, driven on C
//   cmd_bg, cmd_ba           bank group / bank (MR number for MRS)
//   cmd_row                  row address (ACT) or MR opcode in [13:0] (MRS)
//   cmd_col, cmd_ap          column and auto-precharge for RD/WR
//   RESET_n, CKE             DRAM reset and clock enable
//   CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14   command pins
//   C, BG, BA, ADDR, ADDR_17 address pins
//   PARITY                   CA parity
// ---------------------------------------------------------------------------
module ddr4_cmd_driver #(
    parameter int RANK_BITS = 3,
    parameter int BG_BITS   = 2,
    parameter int BA_BITS   = 2,
    parameter int T_RESET   = 200,
    parameter int T_CKE     = 500,
    parameter int T_ACT     = 16,
    parameter int T_RDWR    = 4,
    parameter int T_PRE     = 16,
    parameter int T_REF     = 350,
    parameter int T_MRS     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_type,
    input  logic [RANK_BITS-1:0] cmd_rank,
    input  logic [BG_BITS-1:0]   cmd_bg,
    input  logic [BA_BITS-1:0]   cmd_ba,
    input  logic [17:0]          cmd_row,
    input  logic [9:0]           cmd_col,
    input  logic                 cmd_ap,
    output logic                 RESET_n,
    output logic                 CKE,
    output logic                 CS_n,
    output logic                 ACT_n,
    output logic                 RAS_n_A16,
    output logic                 CAS_n_A15,
    output logic                 WE_n_A14,
    output logic [RANK_BITS-1:0] C,
    output logic [BG_BITS-1:0]   BG,
    output logic [BA_BITS-1:0]   BA,
    output logic [13:0]          ADDR,
    output logic                 ADDR_17,
    output logic                 PARITY
);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;
    localparam logic [2:0] CMD_MRS  = 3'd7;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared down-counter serves both the init phases and the gaps.
    localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_ACT, T_RDWR)),
                                max2(max2(T_PRE, T_REF), T_MRS));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE - 1);
    localparam logic [CNT_W-1:0] LD_ACT   = CNT_W'(T_ACT - 1);
    localparam logic [CNT_W-1:0] LD_RDWR  = CNT_W'(T_RDWR - 1);
    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0] LD_REF   = CNT_W'(T_REF - 1);
    localparam logic [CNT_W-1:0] LD_MRS   = CNT_W'(T_MRS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RST,
        S_CKE,
        S_IDLE,
        S_GAP
    } state_t;

    // CA pins that hold their value through deselect cycles.
    typedef struct packed {
        logic                 act_n;
        logic                 ras_n;
        logic                 cas_n;
        logic                 we_n;
        logic [RANK_BITS-1:0] c;
        logic [BG_BITS-1:0]   bg;
        logic [BA_BITS-1:0]   ba;
        logic                 a17;
        logic [13:0]          addr;
    } ca_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_n_q, reset_n_d;
    logic             cke_q, cke_d;
    logic             cs_n_q, cs_n_d;
    ca_t              ca_q, ca_d;

    assign cmd_ready = (state_q == S_IDLE);

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reset_n_d = reset_n_q;
        cke_d     = cke_q;
        cs_n_d    = 1'b1;
        ca_d      = ca_q;

        unique case (state_q)
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d   = S_CKE;
                    cnt_d     = LD_CKE;
                    reset_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            // CKE rises when the count expires; ready follows one cycle later
            // so the first command never shares a cycle with the CKE edge.
            S_CKE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!cke_q) begin
                    cke_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (cmd_valid && cmd_type != CMD_NOP) begin
                    cs_n_d  = 1'b0;
                    state_d = S_GAP;
                    ca_d.c    = cmd_rank;
                    ca_d.bg   = '0;
                    ca_d.ba   = '0;
                    ca_d.a17  = 1'b0;
                    ca_d.addr = '0;
                    case (cmd_type)
                        CMD_ACT: begin
                            ca_d.act_n = 1'b0;
                            ca_d.ras_n = cmd_row[16];
                            ca_d.cas_n = cmd_row[15];
                            ca_d.we_n  = cmd_row[14];
                            ca_d.bg    = cmd_bg;
                            ca_d.ba    = cmd_ba;
                            ca_d.a17   = cmd_row[17];
                            ca_d.addr  = cmd_row[13:0];
                            cnt_d      = LD_ACT;
                        end
                        CMD_RD, CMD_WR: begin
                            ca_d.act_n = 1'b1;
                            ca_d.ras_n = 1'b1;
                            ca_d.cas_n = 1'b0;
                            ca_d.we_n  = (cmd_type == CMD_RD);
                            ca_d.bg    = cmd_bg;
                            ca_d.ba    = cmd_ba;
                            ca_d.addr  = {3'b000, cmd_ap, cmd_col};
                            cnt_d      = LD_RDWR;
                        end
                        CMD_PRE, CMD_PREA: begin
                            ca_d.act_n    = 1'b1;
                            ca_d.ras_n    = 1'b0;
                            ca_d.cas_n    = 1'b1;
                            ca_d.we_n     = 1'b0;
                            // Bank select only matters for single-bank PRE.
                            if (cmd_type == CMD_PRE) begin
                                ca_d.bg = cmd_bg;
                                ca_d.ba = cmd_ba;
                            end
                            ca_d.addr[10] = (cmd_type == CMD_PREA);
                            cnt_d         = LD_PRE;
                        end
                        CMD_REF: begin
                            ca_d.act_n = 1'b1;
                            ca_d.ras_n = 1'b0;
                            ca_d.cas_n = 1'b0;
                            ca_d.we_n  = 1'b1;
                            cnt_d      = LD_REF;
                        end
                        CMD_MRS: begin
                            ca_d.act_n = 1'b1;
                            ca_d.ras_n = 1'b0;
                            ca_d.cas_n = 1'b0;
                            ca_d.we_n  = 1'b0;
                            ca_d.bg    = cmd_bg;
                            ca_d.ba    = cmd_ba;
                            ca_d.addr  = cmd_row[13:0];
                            cnt_d      = LD_MRS;
                        end
                        default: begin
                            cs_n_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end

            // Loaded with T_x-1 in the accept cycle; leaving when the count
            // reaches 1 puts ready back exactly T_x cycles after the accept.
            S_GAP: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            cnt_q     <= LD_RESET;
            reset_n_q <= 1'b0;
            cke_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            ca_q      <= '0;
            ca_q.act_n <= 1'b1;
            ca_q.ras_n <= 1'b1;
            ca_q.cas_n <= 1'b1;
            ca_q.we_n  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reset_n_q <= reset_n_d;
            cke_q     <= cke_d;
            cs_n_q    <= cs_n_d;
            ca_q      <= ca_d;
        end
    end

`ifdef DDR4_CA_PARITY_EN
    // Even parity over the same-cycle CA pins (C excluded); computed from
    // the next-cycle pin values so it lands in the same cycle as the pins,
    // including deselect cycles where the pins simply hold.
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^{ca_d.act_n, ca_d.ras_n, ca_d.cas_n, ca_d.we_n,
                          ca_d.bg, ca_d.ba, ca_d.a17, ca_d.addr};
        end
    end

    assign PARITY = parity_q;
`else
    assign PARITY = 1'b0;
`endif

    assign RESET_n   = reset_n_q;
    assign CKE       = cke_q;
    assign CS_n      = cs_n_q;
    assign ACT_n     = ca_q.act_n;
    assign RAS_n_A16 = ca_q.ras_n;
    assign CAS_n_A15 = ca_q.cas_n;
    assign WE_n_A14  = ca_q.we_n;
    assign C         = ca_q.c;
    assign BG        = ca_q.bg;
    assign BA        = ca_q.ba;
    assign ADDR      = ca_q.addr;
    assign ADDR_17   = ca_q.a17;

endmodule

// File: tb/tb_ddr4_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_ddr4_cmd_driver
//
// Directed bench for ddr4_cmd_driver. Each issued command pushes its expected
// pin image and expected output edge onto a scoreboard queue; a monitor pops
// and compares whenever CS_n is low. Gaps are checked from accept edges.
// ---------------------------------------------------------------------------
module tb_ddr4_cmd_driver;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
    localparam logic [2:0] PRE = 3'd4, PREA = 3'd5, REF = 3'd6, MRS = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_rank;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [17:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_ap;
    logic        RESET_n, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [2:0]  C;
    logic [1:0]  BG, BA;
    logic [13:0] ADDR;
    logic        ADDR_17, PARITY;

    ddr4_cmd_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_rank  (cmd_rank),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_ap    (cmd_ap),
        .RESET_n   (RESET_n),
        .CKE       (CKE),
        .CS_n      (CS_n),
        .ACT_n     (ACT_n),
        .RAS_n_A16 (RAS_n_A16),
        .CAS_n_A15 (CAS_n_A15),
        .WE_n_A14  (WE_n_A14),
        .C         (C),
        .BG        (BG),
        .BA        (BA),
        .ADDR      (ADDR),
        .ADDR_17   (ADDR_17),
        .PARITY    (PARITY)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pin image {ACT_n, RAS, CAS, WE, C, BG, BA, ADDR, ADDR_17}
    typedef struct {
        logic [25:0] pins;
        int          edge_no;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   next_id  = 0;
    int   last_acc = -1;

    function automatic logic [25:0] mk(input logic act_n, input logic ras, input logic cas,
                                       input logic we, input logic [2:0] c, input logic [1:0] bg,
                                       input logic [1:0] ba, input logic [13:0] addr,
                                       input logic a17);
        return {act_n, ras, cas, we, c, bg, ba, addr, a17};
    endfunction

    // Monitor: scoreboard pop on each CS_n pulse, parity on every cycle.
    logic cs_prev = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (CS_n === 1'b0) begin
            check("cs_single_cycle", {63'd0, cs_prev}, 64'd1);
            if (sb.size() == 0) begin
                check("unexpected_cs", 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("cmd%0d_pins", e.id),
                      {38'd0, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, C, BG, BA, ADDR, ADDR_17},
                      {38'd0, e.pins});
                check($sformatf("cmd%0d_edge", e.id), cycle, e.edge_no);
            end
        end
`ifdef DDR4_CA_PARITY_EN
        check("parity", {63'd0, PARITY},
              {63'd0, ^{ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA, ADDR_17, ADDR}});
`else
        check("parity_tied", {63'd0, PARITY}, 64'd0);
`endif
        cs_prev = CS_n;
    end

    task automatic check_reset_pins(input string tag);
        check(tag, {RESET_n, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                    C, BG, BA, ADDR, ADDR_17, PARITY, cmd_ready},
              {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               3'd0, 2'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0});
    endtask

    // Releases rst at a falling edge and counts rising edges to each event.
    task automatic run_init(input string tag);
        int rn_rise  = -1;
        int cke_rise = -1;
        int rdy_rise = -1;
        int cs_low   = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 710; k++) begin
            @(negedge clk);
            if (RESET_n === 1'b1 && rn_rise < 0)  rn_rise  = k;
            if (CKE === 1'b1 && cke_rise < 0)     cke_rise = k;
            if (cmd_ready === 1'b1 && rdy_rise < 0) rdy_rise = k;
            if (CS_n !== 1'b1)                    cs_low++;
        end
        check({tag, "_reset_n_rise"}, rn_rise, 200);
        check({tag, "_cke_rise"}, cke_rise, 700);
        check({tag, "_ready_rise"}, rdy_rise, 701);
        check({tag, "_no_cs_before_ready"}, cs_low, 0);
        last_acc = -1;
    endtask

    // Offer a command (valid stays high on return) and wait for its accept.
    task automatic send(input logic [2:0] t, input logic [2:0] rank, input logic [1:0] bg,
                        input logic [1:0] ba, input logic [17:0] row, input logic [9:0] col,
                        input logic ap, input logic [25:0] exp_pins, input int gap_exp,
                        input string tag);
        int   w = 0;
        int   acc;
        exp_t e;
        cmd_type  = t;
        cmd_rank  = rank;
        cmd_bg    = bg;
        cmd_ba    = ba;
        cmd_row   = row;
        cmd_col   = col;
        cmd_ap    = ap;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept_in_time"}, {63'd0, w < 1000}, 64'd1);
        acc = cycle + 1;
        if (gap_exp >= 0) check({tag, "_gap"}, acc - last_acc, gap_exp);
        last_acc = acc;
        if (t != NOP) begin
            e.pins    = exp_pins;
            e.edge_no = acc;
            e.id      = next_id;
            next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = NOP;
        cmd_rank  = '0;
        cmd_bg    = '0;
        cmd_ba    = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        cmd_ap    = 1'b0;

        @(negedge clk);
        check_reset_pins("reset_values");
        run_init("init");

        // ACT row 0x2A5C3: A16=0 A15=1 A14=0, A13:0=0x25C3, A17=1
        send(ACT, 3'd1, 2'd2, 2'd3, 18'h2A5C3, 10'h000, 1'b0,
             mk(0, 0, 1, 0, 3'd1, 2'd2, 2'd3, 14'h25C3, 1), -1, "act");
        // RD with junk row; A10=ap
        send(RD, 3'd1, 2'd2, 2'd3, 18'h3FFFF, 10'h3FF, 1'b1,
             mk(1, 1, 0, 1, 3'd1, 2'd2, 2'd3, 14'h07FF, 0), 16, "rd");
        send(WR, 3'd0, 2'd1, 2'd0, 18'h00000, 10'h155, 1'b0,
             mk(1, 1, 0, 0, 3'd0, 2'd1, 2'd0, 14'h0155, 0), 4, "wr1");
        send(WR, 3'd2, 2'd3, 2'd1, 18'h00000, 10'h2AA, 1'b1,
             mk(1, 1, 0, 0, 3'd2, 2'd3, 2'd1, 14'h06AA, 0), 4, "wr2");
        send(NOP, 3'd0, 2'd0, 2'd0, 18'h00000, 10'h000, 1'b0, '0, 4, "nop1");
        // PRE with junk col/ap: A10 must be 0
        send(PRE, 3'd0, 2'd1, 2'd2, 18'h00000, 10'h3FF, 1'b1,
             mk(1, 0, 1, 0, 3'd0, 2'd1, 2'd2, 14'h0000, 0), 1, "pre");
        send(PREA, 3'd3, 2'd0, 2'd0, 18'h00000, 10'h000, 1'b0,
             mk(1, 0, 1, 0, 3'd3, 2'd0, 2'd0, 14'h0400, 0), 16, "prea");
        // MRS MR3 op 0x0400; row[17] set to show A17 stays 0
        send(MRS, 3'd0, 2'd0, 2'd3, 18'h20400, 10'h000, 1'b0,
             mk(1, 0, 0, 0, 3'd0, 2'd0, 2'd3, 14'h0400, 0), 16, "mrs");
        // REF with junk bank/row fields
        send(REF, 3'd0, 2'd3, 2'd3, 18'h3FFFF, 10'h3FF, 1'b1,
             mk(1, 0, 0, 1, 3'd0, 2'd0, 2'd0, 14'h0000, 0), 24, "ref1");
        send(NOP, 3'd0, 2'd0, 2'd0, 18'h00000, 10'h000, 1'b0, '0, 350, "nop2");
        send(REF, 3'd5, 2'd0, 2'd0, 18'h00000, 10'h000, 1'b0,
             mk(1, 0, 0, 1, 3'd5, 2'd0, 2'd0, 14'h0000, 0), 1, "ref2");
        cmd_valid = 1'b0;

        // Mid-REF gap: still busy, pins hold, then asynchronous reset.
        repeat (100) @(negedge clk);
        check("ref_gap_busy", {63'd0, cmd_ready}, 64'd0);
        check("deselect_hold", {59'd0, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, C},
              {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5});
        #1 rst = 1'b1;
        #1 check_reset_pins("mid_gap_reset");
        @(negedge clk);
        @(negedge clk);
        check_reset_pins("reset_held");
        run_init("reinit");

        // ACT row 0x1C000: A16=1 A15=1 A14=1, A13:0=0, A17=0
        send(ACT, 3'd4, 2'd1, 2'd1, 18'h1C000, 10'h000, 1'b0,
             mk(0, 1, 1, 1, 3'd4, 2'd1, 2'd1, 14'h0000, 0), -1, "act_after_reset");
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
